// File: rtl/pipe_adder.sv
// pipe_adder: pipelined two's-complement adder/subtractor with a valid/ready stream.
// The carry chain is split into STAGES chunks of CW = WIDTH/STAGES bits, one register
// boundary per chunk. The whole pipeline stalls together while the output is back-pressured.
//
// Parameters:
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth and chunk count, 1..WIDTH
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (combinational from out_ready)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: s = a + b + cin, 1: s = a - b - cin
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   s          sum/difference modulo 2^WIDTH
//   cout       carry out of the MSB (sub: 1 = no borrow)
//   ovf        signed overflow
module pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic              advance_c;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic              ovf_q, ovf_d;

    // Per-stage skew: operands (a, b_eff) travel with the beat so later stages find
    // their unprocessed chunks; s accumulates the completed lower chunks.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    logic [WIDTH-1:0]  b_eff_c;
    logic [WIDTH-1:0]  src_a_c;
    logic [WIDTH-1:0]  src_b_c;
    logic [CW:0]       sum_c;

    // Single global stall: everything shifts only when the output slot can move.
    assign advance_c = !valid_q[LAST] || out_ready;
    assign in_ready  = advance_c;

    // Next-state of every stage assuming the pipeline advances.
    always_comb begin
        valid_d = '0;
        carry_d = '0;
        ovf_d   = 1'b0;
        src_a_c = '0;
        src_b_c = '0;
        sum_c   = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
            s_d[k] = '0;
        end

        // Subtraction is a + ~b + ~borrow; b and cin are inverted once at entry.
        b_eff_c = sub ? ~b : b;

        // Stage 0 consumes chunk 0 straight from the inputs.
        sum_c      = (CW+1)'(a[CW-1:0]) + (CW+1)'(b_eff_c[CW-1:0]) + (CW+1)'(cin ^ sub);
        valid_d[0] = in_valid;
        carry_d[0] = sum_c[CW];
        a_d[0]     = a;
        b_d[0]     = b_eff_c;
        s_d[0]     = WIDTH'(sum_c[CW-1:0]);
        src_a_c    = a;
        src_b_c    = b_eff_c;

        // Stage k adds chunk k using the carry registered by stage k-1.
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_a_c    = a_q[k-1];
            src_b_c    = b_q[k-1];
            sum_c      = (CW+1)'(src_a_c[k*CW +: CW]) + (CW+1)'(src_b_c[k*CW +: CW])
                       + (CW+1)'(carry_q[k-1]);
            valid_d[k] = valid_q[k-1];
            carry_d[k] = sum_c[CW];
            a_d[k]     = src_a_c;
            b_d[k]     = src_b_c;
            s_d[k]     = s_q[k-1];
            s_d[k][k*CW +: CW] = sum_c[CW-1:0];
        end

        // src_* now hold the operands feeding the last stage, which owns the MSB.
        ovf_d = (src_a_c[WIDTH-1] == src_b_c[WIDTH-1]) &&
                (s_d[LAST][WIDTH-1] != src_a_c[WIDTH-1]);
    end

    // Pipeline registers: synchronous clear, hold on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance_c) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign s         = s_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and random checks of pipe_adder.
// Config 0 (WIDTH=32, STAGES=4) gets hand-computed directed vectors; configs 1..4
// (8/1, 8/2, 8/8, 64/4) get random beats with random in_valid/out_ready.
// Every config is also checked each cycle against an arithmetic reference model.
module tb_pipe_adder;

    localparam int unsigned NCFG = 5;

    function automatic int unsigned cfg_w(input int c);
        case (c)
            0:       return 32;
            4:       return 64;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned cfg_s(input int c);
        case (c)
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    logic clk;
    int   checks;
    int   errors;
    logic dir_done;
    logic rnd_done;
    logic drain_go;

    // Directed stimulus / observation for config 0
    logic        d_rst_n, d_valid, d_cin, d_sub, d_oready;
    logic [31:0] d_a, d_b;
    logic        d_ovalid, d_iready, d_cout, d_ovf;
    logic [31:0] d_s;

    // Random stimulus for configs 1..4
    logic            r_rst_n;
    logic [NCFG-1:0] r_valid, r_cin, r_sub, r_oready;
    logic [63:0]     r_a [NCFG];
    logic [63:0]     r_b [NCFG];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int unsigned W = cfg_w(c);
        localparam int unsigned S = cfg_s(c);

        logic         rst_n, in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
        logic [W-1:0] a, b, s;

        if (c == 0) begin : g_dir
            assign rst_n     = d_rst_n;
            assign in_valid  = d_valid;
            assign a         = d_a[W-1:0];
            assign b         = d_b[W-1:0];
            assign cin       = d_cin;
            assign sub       = d_sub;
            assign out_ready = d_oready;
            assign d_ovalid  = out_valid;
            assign d_iready  = in_ready;
            assign d_s       = s;
            assign d_cout    = cout;
            assign d_ovf     = ovf;
        end else begin : g_rnd
            assign rst_n     = r_rst_n;
            assign in_valid  = r_valid[c];
            assign a         = r_a[c][W-1:0];
            assign b         = r_b[c][W-1:0];
            assign cin       = r_cin[c];
            assign sub       = r_sub[c];
            assign out_ready = r_oready[c];
        end

        pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .s        (s),
            .cout     (cout),
            .ovf      (ovf)
        );

        typedef struct {
            logic [W-1:0] s;
            logic         cout;
            logic         ovf;
            int           tag;
        } exp_t;

        exp_t q[$];
        int   cnt = 0;
        logic due_p, due_n;

        // Reference: plain unsigned and signed arithmetic in W+2 bits.
        function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                       input logic fc, input logic fs);
            logic [W+1:0]        ur;
            logic signed [W+1:0] sr;
            exp_t                e;
            if (!fs) begin
                ur     = (W+2)'(fa) + (W+2)'(fb) + (W+2)'(fc);
                sr     = (W+2)'($signed(fa)) + (W+2)'($signed(fb)) + (W+2)'(fc);
                e.cout = ur[W];
            end else begin
                ur     = (W+2)'(fa) - (W+2)'(fb) - (W+2)'(fc);
                sr     = (W+2)'($signed(fa)) - (W+2)'($signed(fb)) - (W+2)'(fc);
                e.cout = ((W+1)'(fa) >= (W+1)'(fb) + (W+1)'(fc));
            end
            e.s   = ur[W-1:0];
            e.ovf = !((sr[W+1:W-1] == 3'b000) || (sr[W+1:W-1] == 3'b111));
            e.tag = 0;
            return e;
        endfunction

        // Ideal pipeline: a beat is due STAGES-1 advancing edges after its accepting edge.
        always @(posedge clk) begin
            exp_t e;
            if (!rst_n) begin
                q.delete();
            end else begin
                due_p = (q.size() > 0) && (q[0].tag + int'(S) - 1 == cnt);
                if (due_p && out_ready) void'(q.pop_front());
                if (!due_p || out_ready) begin
                    cnt++;
                    if (in_valid) begin
                        e     = model(a, b, cin, sub);
                        e.tag = cnt;
                        q.push_back(e);
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                due_n = (q.size() > 0) && (q[0].tag + int'(S) - 1 == cnt);
                chk($sformatf("c%0d_out_valid", c), 64'(out_valid), 64'(due_n));
                chk($sformatf("c%0d_in_ready", c), 64'(in_ready), 64'(!due_n || out_ready));
                if (due_n) begin
                    chk($sformatf("c%0d_s", c), 64'(s), 64'(q[0].s));
                    chk($sformatf("c%0d_cout", c), 64'(cout), 64'(q[0].cout));
                    chk($sformatf("c%0d_ovf", c), 64'(ovf), 64'(q[0].ovf));
                end
            end
        end

        initial begin
            wait (drain_go);
            chk($sformatf("c%0d_drain", c), 64'(q.size()), 64'd0);
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc, input logic ts);
        d_a = ta; d_b = tb_v; d_cin = tc; d_sub = ts; d_valid = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] es, input logic ec, input logic eo);
        chk({name, "_valid"}, 64'(d_ovalid), 64'd1);
        chk({name, "_s"}, 64'(d_s), 64'(es));
        chk({name, "_cout"}, 64'(d_cout), 64'(ec));
        chk({name, "_ovf"}, 64'(d_ovf), 64'(eo));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!d_ovalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 64'(d_ovalid), 64'd1);
    endtask

    initial begin : directed
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vc [4];
        logic [31:0] es [4];
        logic        ec [4];
        logic        eo [4];
        logic [31:0] res[$];
        int          idx, got, stall;
        logic        acc;

        dir_done = 1'b0;
        d_rst_n = 1'b0; d_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
        d_oready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(d_ovalid), 64'd0);
        chk("rst_s", 64'(d_s), 64'd0);
        chk("rst_cout", 64'(d_cout), 64'd0);
        chk("rst_ovf", 64'(d_ovf), 64'd0);
        d_rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(d_iready), 64'd1);
        @(posedge clk); #1;

        // Single beat: latency STAGES
        send(32'h0, 32'h4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lat_early_valid", 64'(d_ovalid), 64'd0);
        end
        @(negedge clk);
        chk_out("single", 32'h4, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Four back-to-back beats, results on four consecutive cycles
        va = '{32'h4, 32'h4,    32'hFFFFFFFE, 32'h7FFFFFFF};
        vb = '{32'h4, 32'hF004, 32'h1,        32'h1};
        vc = '{1'b0,  1'b1,     1'b1,         1'b0};
        es = '{32'h8, 32'hF009, 32'h0,        32'h80000000};
        ec = '{1'b0,  1'b0,     1'b1,         1'b0};
        eo = '{1'b0,  1'b0,     1'b0,         1'b1};
        for (int i = 0; i < 4; i++) send(va[i], vb[i], vc[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_out("b2b", es[i], ec[i], eo[i]);
        end
        @(posedge clk); #1;

        // Subtraction
        send(32'h5, 32'h7, 1'b0, 1'b1);
        send(32'h80000000, 32'h1, 1'b0, 1'b1);
        wait_valid("sub");
        chk_out("sub0", 32'hFFFFFFFE, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("sub1", 32'h7FFFFFFF, 1'b1, 1'b1);
        @(posedge clk); #1;

        // Backpressure: 6 beats, 3-cycle stall once out_valid rises
        idx = 0; got = 0; stall = -1;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            d_valid = (idx < 6); d_a = 32'(idx + 1); d_b = 32'h10; d_cin = 1'b0; d_sub = 1'b0;
            if (d_ovalid && stall < 0) stall = 3;
            d_oready = !(stall > 0);
            @(negedge clk);
            if (stall > 0) chk("bp_in_ready", 64'(d_iready), 64'd0);
            if (d_ovalid && d_oready) begin
                res.push_back(d_s);
                got++;
            end
            acc = d_valid && d_iready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (stall > 0) stall--;
        end
        d_valid = 1'b0; d_oready = 1'b1;
        chk("bp_count", 64'(got), 64'd6);
        for (int i = 0; i < res.size(); i++) chk("bp_order", 64'(res[i]), 64'(32'h11 + i));

        // Reset mid-flight: no stale beats, fresh beat after STAGES cycles
        send(32'h1, 32'h1, 1'b0, 1'b0);
        send(32'h2, 32'h2, 1'b0, 1'b0);
        send(32'h3, 32'h3, 1'b0, 1'b0);
        d_rst_n = 1'b0;
        @(posedge clk); #1;
        d_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstmid_no_stale", 64'(d_ovalid), 64'd0);
        end
        @(posedge clk); #1;
        send(32'h10, 32'h20, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_early_valid", 64'(d_ovalid), 64'd0);
        end
        @(negedge clk);
        chk_out("rstmid", 32'h30, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        dir_done = 1'b1;
    end

    initial begin : random_stim
        rnd_done = 1'b0;
        r_rst_n  = 1'b0;
        r_valid  = '0; r_cin = '0; r_sub = '0; r_oready = '0;
        for (int c = 0; c < NCFG; c++) begin
            r_a[c] = '0;
            r_b[c] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        r_rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 1; c < NCFG; c++) begin
                r_valid[c]  = ($urandom_range(0, 3) != 0);
                r_a[c]      = {$urandom, $urandom};
                r_b[c]      = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) r_b[c] = ~r_a[c];
                r_cin[c]    = 1'($urandom_range(0, 1));
                r_sub[c]    = 1'($urandom_range(0, 1));
                r_oready[c] = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
        end
        r_valid  = '0;
        r_oready = '1;
        repeat (30) @(posedge clk);
        #1;
        rnd_done = 1'b1;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog timeout");
    end

    initial begin : summary
        checks   = 0;
        errors   = 0;
        drain_go = 1'b0;
        wait (dir_done && rnd_done);
        drain_go = 1'b1;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
